// File: rtl/ntt_bf_sched.sv
// Purpose: address/twiddle scheduler for a 4-pass radix-4 (2x2 butterfly) 256-point NTT/INTT.
// Latency: start to done is 4*(64+MEM_LAT+BF_LAT)+1 cycles; writes trail reads by MEM_LAT+BF_LAT.
// Backpressure: optional stall input (define NTT_SCHED_STALL_EN) freezes issue; delay lines keep draining.
module ntt_bf_sched #(
    parameter int WIDTH   = 23,
    parameter int MEM_LAT = 1,
    parameter int BF_LAT  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        inv,
`ifdef NTT_SCHED_STALL_EN
    input  logic        stall,
`endif
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    output logic [6:0]  tw_addr,
    output logic [2:0]  bf_mode,
    output logic        bf_validi,
    output logic        wr_en,
    output logic [31:0] wr_addr
);

    localparam int DRAIN_N = MEM_LAT + BF_LAT;
    localparam logic [7:0] DRAIN_END = 8'(DRAIN_N - 1);
    // WIDTH only matters to the butterfly datapath; the schedule is width independent.
    localparam logic [2:0] MODE_IDLE = (WIDTH > 0) ? 3'd7 : 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_pass;
    logic [5:0]  r_k;
    logic [7:0]  r_dcnt;
    logic        r_inv;
    logic        w_stall;
    logic        w_issue;
    logic [2:0]  w_sh;
    logic [7:0]  w_s, w_j, w_g, w_base;
    logic [6:0]  w_off;
    logic [31:0] w_rd_addr;

    logic        r_vmem [MEM_LAT];
    logic        r_vbf  [BF_LAT];
    logic [31:0] r_adl  [DRAIN_N];

`ifdef NTT_SCHED_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_issue = (r_state == S_ISSUE) && !w_stall;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: issue 64 butterflies, drain the pipeline, repeat for 4 passes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ISSUE;
            S_ISSUE: if (w_issue && r_k == 6'd63) w_next = S_DRAIN;
            S_DRAIN: if (r_dcnt == DRAIN_END) w_next = (r_pass == 2'd3) ? S_DONE : S_ISSUE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pass / butterfly / drain counters and the mode latched at start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass <= 2'd0;
            r_k    <= 6'd0;
            r_dcnt <= 8'd0;
            r_inv  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_pass <= 2'd0;
                    r_k    <= 6'd0;
                    r_inv  <= inv;
                end
                S_ISSUE: begin
                    r_dcnt <= 8'd0;
                    if (w_issue) r_k <= r_k + 6'd1;
                end
                S_DRAIN: begin
                    r_dcnt <= r_dcnt + 8'd1;
                    if (r_dcnt == DRAIN_END) r_pass <= r_pass + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Index generation: stride 4^(3-p) forward, 4^p inverse; twiddle = pass offset + group.
    always_comb begin
        w_sh      = r_inv ? {r_pass, 1'b0} : {~r_pass, 1'b0};
        w_s       = 8'd1 << w_sh;
        w_j       = {2'b00, r_k} & (w_s - 8'd1);
        w_g       = {2'b00, r_k} >> w_sh;
        w_base    = (w_g << ({1'b0, w_sh} + 4'd2)) | w_j;
        w_rd_addr = {w_base + 8'd3 * w_s, w_base + 8'd2 * w_s, w_base + w_s, w_base};
        w_off     = 7'd0;
        case ({r_inv, r_pass})
            3'b000: w_off = 7'd0;
            3'b001: w_off = 7'd1;
            3'b010: w_off = 7'd5;
            3'b011: w_off = 7'd21;
            3'b100: w_off = 7'd0;
            3'b101: w_off = 7'd64;
            3'b110: w_off = 7'd80;
            3'b111: w_off = 7'd84;
            default: w_off = 7'd0;
        endcase
    end

    // Read-side delay to the butterfly, butterfly delay to write-back, and address delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) r_vmem[i] <= 1'b0;
            for (int i = 0; i < BF_LAT; i++)  r_vbf[i]  <= 1'b0;
            for (int i = 0; i < DRAIN_N; i++) r_adl[i]  <= 32'd0;
        end else begin
            r_vmem[0] <= w_issue;
            for (int i = 1; i < MEM_LAT; i++) r_vmem[i] <= r_vmem[i-1];
            r_vbf[0] <= r_vmem[MEM_LAT-1];
            for (int i = 1; i < BF_LAT; i++) r_vbf[i] <= r_vbf[i-1];
            r_adl[0] <= w_issue ? w_rd_addr : 32'd0;
            for (int i = 1; i < DRAIN_N; i++) r_adl[i] <= r_adl[i-1];
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign rd_en     = w_issue;
    assign rd_addr   = w_issue ? w_rd_addr : 32'd0;
    assign tw_addr   = w_issue ? (w_off + w_g[6:0]) : 7'd0;
    assign bf_mode   = (r_state == S_IDLE) ? MODE_IDLE : {2'b00, r_inv};
    assign bf_validi = r_vmem[MEM_LAT-1];
    assign wr_en     = r_vbf[BF_LAT-1];
    assign wr_addr   = r_adl[DRAIN_N-1];

endmodule

// File: tb/tb_ntt_bf_sched.sv
// Purpose: directed self-checking bench for ntt_bf_sched (forward, inverse, restart, reset, stall).
// Latency: cycle N is the clock period after the N-th edge following the start edge.
// Backpressure: stall window exercised only when NTT_SCHED_STALL_EN is defined.
module tb_ntt_bf_sched;

    logic        clk, rst, start, inv;
`ifdef NTT_SCHED_STALL_EN
    logic        stall;
`endif
    logic        busy, done, rd_en, bf_validi, wr_en;
    logic [31:0] rd_addr, wr_addr;
    logic [6:0]  tw_addr;
    logic [2:0]  bf_mode;

    int          cyc, n_chk, n_err;
    int          nrd, nwr, nvi, done_cyc, first_rd1, last_wr0;
    logic [31:0] cap_a [4];
    logic [6:0]  cap_t [4];
    int          hits  [4][256];
    int          q_cyc [$];
    logic [31:0] q_addr[$];

    ntt_bf_sched dut (
        .clk(clk), .rst(rst), .start(start), .inv(inv),
`ifdef NTT_SCHED_STALL_EN
        .stall(stall),
`endif
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .tw_addr(tw_addr), .bf_mode(bf_mode), .bf_validi(bf_validi),
        .wr_en(wr_en), .wr_addr(wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start a transform and monitor it until done, stop_at, or a 400-cycle budget.
    task automatic run(input logic iv, input int stop_at, input int restart_at,
                       input int stall_lo, input int stall_hi);
        int          c, bad;
        logic [31:0] a;
        logic        st;
        nrd = 0; nwr = 0; nvi = 0; done_cyc = 0; first_rd1 = 0; last_wr0 = 0;
        q_cyc.delete(); q_addr.delete();
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 256; i++) hits[p][i] = 0;
        cyc = 0; inv = iv; start = 1'b1;
        step();
        start = 1'b0;
        while (done_cyc == 0 && cyc < 400 && cyc != stop_at) begin
            st = (cyc >= stall_lo) && (cyc <= stall_hi);
`ifdef NTT_SCHED_STALL_EN
            stall = st;
`endif
            #1;
            if (st) check("stall_no_rd", rd_en, 1'b0);
            if (rd_en) begin
                if (nrd < 256) begin
                    for (int m = 0; m < 4; m++) hits[nrd/64][rd_addr[8*m +: 8]]++;
                    if (nrd == 0)   begin cap_a[0] = rd_addr; cap_t[0] = tw_addr; end
                    if (nrd == 1)   begin cap_a[1] = rd_addr; cap_t[1] = tw_addr; end
                    if (nrd == 192) begin cap_a[2] = rd_addr; cap_t[2] = tw_addr; end
                    if (nrd == 193) begin cap_a[3] = rd_addr; cap_t[3] = tw_addr; end
                    if (nrd == 64)  first_rd1 = cyc;
                end else begin
                    check("extra_rd", 1'b1, 1'b0);
                end
                q_cyc.push_back(cyc);
                q_addr.push_back(rd_addr);
                nrd++;
            end
            if (bf_validi) nvi++;
            if (wr_en) begin
                if (q_cyc.size() == 0) begin
                    check("wr_unexpected", 1'b1, 1'b0);
                end else begin
                    c = q_cyc.pop_front();
                    a = q_addr.pop_front();
                    check("wr_lat", 64'(cyc), 64'(c + 8));
                    check("wr_addr", wr_addr, a);
                end
                nwr++;
                if (nwr == 64) last_wr0 = cyc;
            end
            if (busy) check("mode_hold", bf_mode, {2'b00, iv});
            if (done) done_cyc = cyc;
            start = (cyc == restart_at);
            inv   = (cyc == restart_at) ? ~iv : iv;
            step();
        end
        start = 1'b0;
        inv   = iv;
`ifdef NTT_SCHED_STALL_EN
        stall = 1'b0;
`endif
        if (done_cyc != 0) begin
            bad = 0;
            for (int p = 0; p < 4; p++)
                for (int i = 0; i < 256; i++) if (hits[p][i] != 1) bad++;
            check("index_coverage", 64'(bad), 64'd0);
            check("num_rd", 64'(nrd), 64'd256);
            check("num_vi", 64'(nvi), 64'd256);
            check("num_wr", 64'(nwr), 64'd256);
        end
    endtask

    initial begin
        int nw, nd;
        n_chk = 0; n_err = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; inv = 1'b0;
`ifdef NTT_SCHED_STALL_EN
        stall = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_validi", bf_validi, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_mode", bf_mode, 3'd7);
        check("rst_rd_addr", rd_addr, 32'd0);
        check("rst_wr_addr", wr_addr, 32'd0);
        check("rst_tw_addr", tw_addr, 7'd0);

        // Forward transform.
        run(1'b0, -1, -1, -1, -1);
        check("fwd_first_addr", cap_a[0], 32'hC0804000);
        check("fwd_first_tw", cap_t[0], 7'd0);
        check("fwd_p3k0_addr", cap_a[2], 32'h03020100);
        check("fwd_p3k0_tw", cap_t[2], 7'd21);
        check("fwd_done_cyc", 64'(done_cyc), 64'd289);
        check("fwd_pass_gap", first_rd1 > last_wr0, 1'b1);
        check("fwd_idle_busy", busy, 1'b0);
        check("fwd_idle_mode", bf_mode, 3'd7);

        // Inverse transform with a spurious start (and flipped inv) at cycle 100.
        run(1'b1, -1, 100, -1, -1);
        check("inv_p0k1_addr", cap_a[1], 32'h07060504);
        check("inv_p0k1_tw", cap_t[1], 7'd1);
        check("inv_p3k1_addr", cap_a[3], 32'hC1814101);
        check("inv_p3k1_tw", cap_t[3], 7'd84);
        check("inv_done_cyc", 64'(done_cyc), 64'd289);

        // Reset in the middle of a forward transform.
        run(1'b0, 150, -1, -1, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_mode", bf_mode, 3'd7);
        check("abort_rd_en", rd_en, 1'b0);
        nw = 0; nd = 0;
        for (int i = 0; i < 300; i++) begin
            if (wr_en) nw++;
            if (done) nd++;
            step();
        end
        check("abort_no_wr", 64'(nw), 64'd0);
        check("abort_no_done", 64'(nd), 64'd0);

`ifdef NTT_SCHED_STALL_EN
        // Ten stalled cycles in pass 1 push done out by ten cycles.
        run(1'b0, -1, -1, 90, 99);
        check("stall_done_cyc", 64'(done_cyc), 64'd299);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
